// File: rtl/prim_ram_arb_pkg.sv
// Shared types for the two-requester RAM arbiter: controller states and requester IDs.
package prim_ram_arb_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic {
    ReqA = 1'b0,
    ReqB = 1'b1
  } req_id_e;

  // Round-robin hand-off: after a grant, the other requester gets preference.
  function automatic req_id_e other_req(input req_id_e id);
    return (id == ReqA) ? ReqB : ReqA;
  endfunction

endpackage

// File: rtl/prim_ram_arb.sv
// Two-way round-robin arbiter in front of one RAM port, with a clear-on-reset
// (and on-demand) sweep that zeroes every word before requesters are served.
module prim_ram_arb
  import prim_ram_arb_pkg::*;
#(
  parameter int Width = 32,
  parameter int Depth = 128,
  parameter int Aw    = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             init_req_i,
  output logic             init_done_o,

  input  logic             a_req_i,
  input  logic             a_write_i,
  input  logic [Aw-1:0]    a_addr_i,
  input  logic [Width-1:0] a_wdata_i,
  output logic             a_gnt_o,
  output logic             a_rvalid_o,
  output logic [Width-1:0] a_rdata_o,

  input  logic             b_req_i,
  input  logic             b_write_i,
  input  logic [Aw-1:0]    b_addr_i,
  input  logic [Width-1:0] b_wdata_i,
  output logic             b_gnt_o,
  output logic             b_rvalid_o,
  output logic [Width-1:0] b_rdata_o,

  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  input  logic [Width-1:0] ram_rdata_i
);

  localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

  state_e          state_q, state_d;
  logic [Aw-1:0]   cnt_q, cnt_d;
  req_id_e         prio_q, prio_d;

  logic            gnt_a, gnt_b, gnt_any;
  req_id_e         gnt_id;
  logic            sel_write;
  logic [Aw-1:0]   sel_addr;
  logic [Width-1:0] sel_wdata;

  logic            vld_p1;
  req_id_e         owner_p1;

  // Arbitration: a lone requester always wins, a tie goes to the preferred one.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (state_q == RUN) begin
      if (a_req_i && (!b_req_i || prio_q == ReqA)) begin
        gnt_a = 1'b1;
      end else if (b_req_i) begin
        gnt_b = 1'b1;
      end
    end
  end

  assign gnt_any   = gnt_a | gnt_b;
  assign gnt_id    = gnt_b ? ReqB : ReqA;
  assign sel_write = gnt_b ? b_write_i : a_write_i;
  assign sel_addr  = gnt_b ? b_addr_i  : a_addr_i;
  assign sel_wdata = gnt_b ? b_wdata_i : a_wdata_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT;
      cnt_q   <= '0;
      prio_q  <= ReqA;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
    end
  end

  // Next-state logic; the counter rests at 0 in RUN so a re-clear starts at address 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    prio_d  = prio_q;
    unique case (state_q)
      INIT: begin
        if (cnt_q == LastAddr) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + Aw'(1);
        end
      end
      RUN: begin
        if (init_req_i) begin
          state_d = INIT;
        end
        if (gnt_any) begin
          prio_d = other_req(gnt_id);
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Output logic
  always_comb begin
    init_done_o = 1'b0;
    ram_req_o   = 1'b0;
    ram_write_o = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    a_gnt_o     = 1'b0;
    b_gnt_o     = 1'b0;
    unique case (state_q)
      INIT: begin
        ram_req_o   = 1'b1;
        ram_write_o = 1'b1;
        ram_addr_o  = cnt_q;
      end
      RUN: begin
        init_done_o = 1'b1;
        a_gnt_o     = gnt_a;
        b_gnt_o     = gnt_b;
        if (gnt_any) begin
          ram_req_o   = 1'b1;
          ram_write_o = sel_write;
          ram_addr_o  = sel_addr;
          ram_wdata_o = sel_wdata;
        end
      end
      default: ;
    endcase
  end

  // ---- p1: read-response stage, aligned with the RAM's one-cycle latency ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1   <= 1'b0;
      owner_p1 <= ReqA;
    end else begin
      vld_p1 <= gnt_any & ~sel_write;
      if (gnt_any) begin
        owner_p1 <= gnt_id;
      end
    end
  end

  assign a_rvalid_o = vld_p1 && (owner_p1 == ReqA);
  assign b_rvalid_o = vld_p1 && (owner_p1 == ReqB);
  assign a_rdata_o  = a_rvalid_o ? ram_rdata_i : '0;
  assign b_rdata_o  = b_rvalid_o ? ram_rdata_i : '0;

endmodule

// File: tb/tb_prim_ram_arb.sv
// Randomized and directed bench for prim_ram_arb against a behavioural model and a RAM stand-in.
module tb_prim_ram_arb;

  localparam int Width = 32;
  localparam int Depth = 128;
  localparam int Aw    = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_ni, init_req_i, init_done_o;
  logic             a_req_i, a_write_i, a_gnt_o, a_rvalid_o;
  logic [Aw-1:0]    a_addr_i;
  logic [Width-1:0] a_wdata_i, a_rdata_o;
  logic             b_req_i, b_write_i, b_gnt_o, b_rvalid_o;
  logic [Aw-1:0]    b_addr_i;
  logic [Width-1:0] b_wdata_i, b_rdata_o;
  logic             ram_req_o, ram_write_o;
  logic [Aw-1:0]    ram_addr_o;
  logic [Width-1:0] ram_wdata_o, ram_rdata;

  prim_ram_arb #(.Width(Width), .Depth(Depth), .Aw(Aw)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .init_req_i(init_req_i), .init_done_o(init_done_o),
    .a_req_i(a_req_i), .a_write_i(a_write_i), .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i),
    .a_gnt_o(a_gnt_o), .a_rvalid_o(a_rvalid_o), .a_rdata_o(a_rdata_o),
    .b_req_i(b_req_i), .b_write_i(b_write_i), .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i),
    .b_gnt_o(b_gnt_o), .b_rvalid_o(b_rvalid_o), .b_rdata_o(b_rdata_o),
    .ram_req_o(ram_req_o), .ram_write_o(ram_write_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata)
  );

  // RAM stand-in: 1-cycle read latency, garbage on the data bus when not reading.
  logic [Width-1:0] ram_mem [Depth];
  initial for (int i = 0; i < Depth; i++) ram_mem[i] = $urandom;
  always @(posedge clk) begin
    if (ram_req_o && ram_write_o) ram_mem[ram_addr_o] <= ram_wdata_o;
    if (ram_req_o && !ram_write_o) ram_rdata <= ram_mem[ram_addr_o];
    else ram_rdata <= $urandom;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: clearing sweep, preferred requester, expected memory image,
  // and the read response owed next cycle.
  logic [Width-1:0] ref_mem [Depth];
  initial begin
    bit m_clr, m_pa, m_pb, e_req, e_wr;
    int m_caddr, m_pref, win, e_addr;
    logic [Width-1:0] m_pdata, e_wd;
    for (int i = 0; i < Depth; i++) ref_mem[i] = '0;
    m_clr = 1; m_caddr = 0; m_pref = 0; m_pa = 0; m_pb = 0; m_pdata = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_ni) begin
        m_clr = 1; m_caddr = 0; m_pref = 0; m_pa = 0; m_pb = 0;
      end
      win = -1;
      if (!m_clr) begin
        if (a_req_i && b_req_i) win = m_pref;
        else if (a_req_i) win = 0;
        else if (b_req_i) win = 1;
      end
      e_req  = m_clr || (win >= 0);
      e_wr   = m_clr ? 1'b1 : (win == 0 ? a_write_i : (win == 1 ? b_write_i : 1'b0));
      e_addr = m_clr ? m_caddr : (win == 0 ? int'(a_addr_i) : (win == 1 ? int'(b_addr_i) : 0));
      e_wd   = m_clr ? '0 : (win == 0 ? a_wdata_i : (win == 1 ? b_wdata_i : '0));

      chk("init_done", init_done_o, !m_clr);
      chk("a_gnt", a_gnt_o, win == 0);
      chk("b_gnt", b_gnt_o, win == 1);
      chk("ram_req", ram_req_o, e_req);
      chk("ram_write", ram_write_o, e_wr);
      chk("ram_addr", ram_addr_o, e_addr);
      chk("ram_wdata", ram_wdata_o, e_wd);
      chk("a_rvalid", a_rvalid_o, m_pa);
      chk("a_rdata", a_rdata_o, m_pa ? m_pdata : '0);
      chk("b_rvalid", b_rvalid_o, m_pb);
      chk("b_rdata", b_rdata_o, m_pb ? m_pdata : '0);

      if (rst_ni) begin
        m_pa = (win == 0) && !e_wr;
        m_pb = (win == 1) && !e_wr;
        if (win >= 0 && !e_wr) m_pdata = ref_mem[e_addr];
        if (e_req && e_wr) ref_mem[e_addr] = e_wd;
        if (win >= 0) m_pref = 1 - win;
        if (m_clr) begin
          if (m_caddr == Depth - 1) begin m_clr = 0; m_caddr = 0; end
          else m_caddr++;
        end else if (init_req_i) begin
          m_clr = 1; m_caddr = 0;
        end
      end
    end
  end

  task automatic idle();
    a_req_i = 0; a_write_i = 0; a_addr_i = '0; a_wdata_i = '0;
    b_req_i = 0; b_write_i = 0; b_addr_i = '0; b_wdata_i = '0;
    init_req_i = 0;
  endtask

  task automatic wait_run();
    for (int i = 0; i < 400 && !init_done_o; i++) begin
      @(negedge clk); idle(); #3;
    end
    chk("wait_run", init_done_o, 1'b1);
  endtask

  initial begin
    idle();
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    a_req_i = 1; a_addr_i = 7'd3;
    @(negedge clk); #3;
    chk("rst_done", init_done_o, 1'b0);
    chk("rst_gnt", a_gnt_o, 1'b0);
    @(negedge clk);
    rst_ni = 1'b1;
    // Clear sweep after reset, with A held pending.
    for (int i = 0; i < 128; i++) begin
      #3;
      chk("clr_addr", ram_addr_o, i);
      chk("clr_gnt", a_gnt_o, 1'b0);
      @(negedge clk);
    end
    #3;
    chk("done_at_128", init_done_o, 1'b1);
    chk("pending_gnt", a_gnt_o, 1'b1);

    // A writes 5, B reads it back.
    @(negedge clk); idle();
    a_req_i = 1; a_write_i = 1; a_addr_i = 7'd5; a_wdata_i = 32'hDEADBEEF;
    @(negedge clk); idle();
    b_req_i = 1; b_addr_i = 7'd5;
    @(negedge clk); idle(); #3;
    chk("b_rvalid_5", b_rvalid_o, 1'b1);
    chk("b_rdata_5", b_rdata_o, 32'hDEADBEEF);
    chk("a_rvalid_5", a_rvalid_o, 1'b0);

    // Lone B while A is preferred.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle();
      b_req_i = 1; b_addr_i = 7'(i); #3;
      chk("lone_b", b_gnt_o, 1'b1);
    end

    // Both reading every cycle: alternation starting with A.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); idle();
      a_req_i = 1; a_addr_i = 7'(i); b_req_i = 1; b_addr_i = 7'(i + 40); #3;
      chk("alt_a", a_gnt_o, (i % 2) == 0);
      chk("alt_b", b_gnt_o, (i % 2) == 1);
    end

    // Randomized traffic with occasional re-clear and reset pulses.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_ni     = ($urandom_range(0, 599) != 0);
      init_req_i = ($urandom_range(0, 149) == 0);
      a_req_i    = $urandom_range(0, 1);
      a_write_i  = $urandom_range(0, 1);
      a_addr_i   = 7'($urandom_range(0, Depth - 1));
      a_wdata_i  = $urandom;
      b_req_i    = $urandom_range(0, 1);
      b_write_i  = $urandom_range(0, 1);
      b_addr_i   = 7'($urandom_range(0, Depth - 1));
      b_wdata_i  = $urandom;
    end
    @(negedge clk); rst_ni = 1'b1; idle();

    // Re-clear requested in the same cycle A reads address 7.
    wait_run();
    @(negedge clk); idle();
    a_req_i = 1; a_write_i = 1; a_addr_i = 7'd7; a_wdata_i = 32'h12345678;
    @(negedge clk);
    a_write_i = 0; init_req_i = 1; #3;
    chk("init_req_gnt", a_gnt_o, 1'b1);
    @(negedge clk); idle(); #3;
    chk("late_rvalid", a_rvalid_o, 1'b1);
    chk("late_rdata", a_rdata_o, 32'h12345678);
    chk("reclear_done", init_done_o, 1'b0);
    for (int j = 1; j < 128; j++) begin
      @(negedge clk); #3;
      chk("reclear_busy", init_done_o, 1'b0);
    end
    @(negedge clk);
    a_req_i = 1; a_addr_i = 7'd7; #3;
    chk("reclear_run", init_done_o, 1'b1);
    @(negedge clk); idle(); #3;
    chk("cleared_rvalid", a_rvalid_o, 1'b1);
    chk("cleared_rdata", a_rdata_o, 32'h0);

    // Reset in the middle of a clear at address 60.
    @(negedge clk); init_req_i = 1;
    @(negedge clk); idle();
    for (int i = 0; i < 60; i++) begin
      #3; chk("mid_addr", ram_addr_o, i);
      @(negedge clk);
    end
    rst_ni = 1'b0; #3;
    chk("mid_rst_addr", ram_addr_o, 0);
    @(negedge clk); rst_ni = 1'b1;
    for (int i = 0; i < 128; i++) begin
      #3;
      chk("restart_addr", ram_addr_o, i);
      chk("restart_done", init_done_o, 1'b0);
      @(negedge clk);
    end
    #3;
    chk("restart_done_128", init_done_o, 1'b1);

    @(negedge clk); #4;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
